// File: rtl/ship_ctl.sv
// ship_ctl -- player ship controller.
//
// Moves the ship left/right once per frame, tracks lives, and sequences
// the ALIVE -> DEAD -> ALIVE respawn cycle and the GAME_OVER / restart path.
// The frame tick is the rising edge of vsync, detected locally.
//
// Optional feature (compile-time macro SHIP_INVULN_EN):
//   when defined, every respawn opens an invulnerability window of
//   INVULN_FRAMES frame ticks during which hit is ignored (movement still
//   works). The window is cleared by rst and by the start-driven restart.
//   When undefined, no invulnerability logic exists.
//
// Ports:
//   pclk       in   pixel clock, all state changes on its rising edge
//   rst        in   asynchronous active-high reset
//   vsync      in   vertical sync; its rising edge is the frame tick
//   btn_left   in   move-left request (synchronous to pclk)
//   btn_right  in   move-right request (synchronous to pclk)
//   hit        in   single-cycle collision pulse
//   start      in   restart request, only acted on in GAME_OVER
//   xpos       out  [10:0] registered ship left-edge x position
//   dead_ship  out  registered, high in DEAD and GAME_OVER
//   lives      out  [1:0] registered remaining lives
//   game_over  out  registered, high only in GAME_OVER
//   dbg_state  out  [1:0] current FSM state (0 ALIVE, 1 DEAD, 2 GAME_OVER)
//
// Handshake note: there is no valid/ready traffic here. hit and start are
// level-sampled on every pclk edge; hit is expected to be a one-cycle pulse.

module ship_ctl #(
    parameter int XSTART         = 488,
    parameter int XMIN           = 0,
    parameter int XMAX           = 976,
    parameter int STEP           = 4,
    parameter int LIVES          = 3,
    parameter int RESPAWN_FRAMES = 60,
    parameter int INVULN_FRAMES  = 90
) (
    input  logic        pclk,
    input  logic        rst,
    input  logic        vsync,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic        hit,
    input  logic        start,
    output logic [10:0] xpos,
    output logic        dead_ship,
    output logic [1:0]  lives,
    output logic        game_over,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        ALIVE     = 2'd0,
        DEAD      = 2'd1,
        GAME_OVER = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        vsync_q;
    logic        tick;
    logic [10:0] xpos_q, xpos_d;
    logic [1:0]  lives_q, lives_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        dead_q, dead_d;
    logic        go_q, go_d;
    logic        hit_eff;

    logic [11:0] x_ext;
    logic [11:0] x_left;
    logic [11:0] x_right;
    logic [10:0] x_move;

    assign tick  = vsync & ~vsync_q;
    assign x_ext = {1'b0, xpos_q};

    // Clamp in 12 bits: compare before subtracting so a position below
    // STEP saturates at XMIN instead of wrapping.
    always_comb begin
        x_left  = (x_ext < 12'(XMIN + STEP)) ? 12'(XMIN) : (x_ext - 12'(STEP));
        x_right = ((x_ext + 12'(STEP)) > 12'(XMAX)) ? 12'(XMAX) : (x_ext + 12'(STEP));
    end

    // Both or neither button held: hold position.
    always_comb begin
        x_move = xpos_q;
        if (btn_left && !btn_right) begin
            x_move = x_left[10:0];
        end else if (btn_right && !btn_left) begin
            x_move = x_right[10:0];
        end
    end

`ifdef SHIP_INVULN_EN
    logic [7:0] inv_q, inv_d;
    logic       respawn;
    logic       restart;

    assign respawn = (state_q == DEAD) && (state_d == ALIVE);
    assign restart = (state_q == GAME_OVER) && (state_d == ALIVE);
    assign hit_eff = hit && (inv_q == 8'd0);

    // Counts remaining protected frames; decrements only while ALIVE.
    always_comb begin
        inv_d = inv_q;
        if (restart) begin
            inv_d = 8'd0;
        end else if (respawn) begin
            inv_d = 8'(INVULN_FRAMES);
        end else if ((state_q == ALIVE) && tick && (inv_q != 8'd0)) begin
            inv_d = inv_q - 8'd1;
        end
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            inv_q <= 8'd0;
        end else begin
            inv_q <= inv_d;
        end
    end
`else
    assign hit_eff = hit;
`endif

    always_comb begin
        state_d = state_q;
        xpos_d  = xpos_q;
        lives_d = lives_q;
        cnt_d   = cnt_q;
        case (state_q)
            ALIVE: begin
                // A hit takes priority over a same-cycle tick: no movement.
                if (hit_eff) begin
                    if (lives_q > 2'd1) begin
                        state_d = DEAD;
                        lives_d = lives_q - 2'd1;
                        cnt_d   = 8'd0;
                    end else begin
                        state_d = GAME_OVER;
                        lives_d = 2'd0;
                    end
                end else if (tick) begin
                    xpos_d = x_move;
                end
            end
            DEAD: begin
                if (tick) begin
                    cnt_d = cnt_q + 8'd1;
                    if ((cnt_q + 8'd1) == 8'(RESPAWN_FRAMES)) begin
                        state_d = ALIVE;
                        xpos_d  = 11'(XSTART);
                    end
                end
            end
            GAME_OVER: begin
                if (start) begin
                    state_d = ALIVE;
                    lives_d = 2'(LIVES);
                    xpos_d  = 11'(XSTART);
                end
            end
            default: begin
                state_d = ALIVE;
            end
        endcase
        // Status flags come from the next state so they switch with it.
        dead_d = (state_d != ALIVE);
        go_d   = (state_d == GAME_OVER);
    end

    always_ff @(posedge pclk or posedge rst) begin
        if (rst) begin
            state_q <= ALIVE;
            vsync_q <= 1'b0;
            xpos_q  <= 11'(XSTART);
            lives_q <= 2'(LIVES);
            cnt_q   <= 8'd0;
            dead_q  <= 1'b0;
            go_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            vsync_q <= vsync;
            xpos_q  <= xpos_d;
            lives_q <= lives_d;
            cnt_q   <= cnt_d;
            dead_q  <= dead_d;
            go_q    <= go_d;
        end
    end

    assign xpos      = xpos_q;
    assign lives     = lives_q;
    assign dead_ship = dead_q;
    assign game_over = go_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_ship_ctl.sv
// tb_ship_ctl -- bench for ship_ctl.
// A second instance (u_edge, XSTART=2) shares the stimulus and is only
// inspected for the screen-edge clamp cases.

module tb_ship_ctl;

    localparam int XSTART  = 488;
    localparam int XMIN    = 0;
    localparam int XMAX    = 976;
    localparam int STEP    = 4;
    localparam int LIVES   = 3;
    localparam int RESPAWN = 60;
`ifdef SHIP_INVULN_EN
    localparam int INV = 90;
`else
    localparam int INV = 0;
`endif

    // ---------------- clock / reset ----------------
    logic pclk = 1'b0;
    logic rst = 1'b0;
    logic vsync = 1'b0;
    logic btn_left = 1'b0;
    logic btn_right = 1'b0;
    logic hit = 1'b0;
    logic start = 1'b0;

    always #5 pclk = ~pclk;

    logic [10:0] xpos;
    logic        dead_ship;
    logic [1:0]  lives;
    logic        game_over;
    logic [1:0]  dbg_state;

    logic [10:0] e_xpos;
    logic        e_dead_ship;
    logic [1:0]  e_lives;
    logic        e_game_over;
    logic [1:0]  e_dbg_state;

    ship_ctl dut (
        .pclk(pclk), .rst(rst), .vsync(vsync), .btn_left(btn_left),
        .btn_right(btn_right), .hit(hit), .start(start), .xpos(xpos),
        .dead_ship(dead_ship), .lives(lives), .game_over(game_over),
        .dbg_state(dbg_state)
    );

    ship_ctl #(.XSTART(2)) u_edge (
        .pclk(pclk), .rst(rst), .vsync(vsync), .btn_left(btn_left),
        .btn_right(btn_right), .hit(hit), .start(start), .xpos(e_xpos),
        .dead_ship(e_dead_ship), .lives(e_lives), .game_over(e_game_over),
        .dbg_state(e_dbg_state)
    );

    wire [14:0] dut_vec = {xpos, lives, dead_ship, game_over};

    int n_cmp = 0;
    int n_err = 0;
    logic [14:0] exp_q[$];

    // ---------------- reference model ----------------
    // Ship described by position, lives left, frames still to wait before
    // respawn, and frames of protection left. Game over == no lives.
    int m_x;
    int m_lives;
    int m_dead_left;
    int m_inv;
    bit m_vs_prev;

    task automatic model_reset();
        m_x = XSTART;
        m_lives = LIVES;
        m_dead_left = 0;
        m_inv = 0;
        m_vs_prev = 1'b0;
    endtask

    task automatic model_step();
        bit t;
        t = vsync && !m_vs_prev;
        m_vs_prev = vsync;
        if (m_lives == 0) begin
            if (start) begin
                m_lives = LIVES;
                m_x = XSTART;
                m_inv = 0;
            end
        end else if (m_dead_left > 0) begin
            if (t) begin
                m_dead_left--;
                if (m_dead_left == 0) begin
                    m_x = XSTART;
                    m_inv = INV;
                end
            end
        end else if (hit && m_inv == 0) begin
            m_lives--;
            if (m_lives > 0) m_dead_left = RESPAWN;
        end else if (t) begin
            if (m_inv > 0) m_inv--;
            if (btn_left && !btn_right) begin
                m_x = (m_x - STEP < XMIN) ? XMIN : m_x - STEP;
            end else if (btn_right && !btn_left) begin
                m_x = (m_x + STEP > XMAX) ? XMAX : m_x + STEP;
            end
        end
    endtask

    function automatic logic [14:0] model_vec();
        logic d;
        logic g;
        d = (m_lives == 0) || (m_dead_left > 0);
        g = (m_lives == 0);
        return {11'(m_x), 2'(m_lives), d, g};
    endfunction

    // ---------------- driver tasks ----------------
    // Inputs change at the falling edge; outputs are read there too.
    task automatic cycle();
        @(posedge pclk);
        if (!rst) model_step();
        @(negedge pclk);
    endtask

    task automatic do_tick();
        vsync = 1'b1;
        cycle();
        vsync = 1'b0;
        cycle();
    endtask

    task automatic pulse_hit();
        hit = 1'b1;
        cycle();
        hit = 1'b0;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        #1;
        model_reset();
        @(negedge pclk);
        rst = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec !== {11'd488, 2'd3, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_values: got %h expected %h", dut_vec, {11'd488, 2'd3, 1'b0, 1'b0});
        end
        @(negedge pclk);
        rst = 1'b0;
    endtask

    task automatic test_move();
        apply_reset();
        btn_right = 1'b1;
        repeat (10) do_tick();
        n_cmp++;
        if (xpos !== 11'd528) begin
            n_err++;
            $display("FAIL move_right10: got %0d expected 528", xpos);
        end
        btn_right = 1'b0;
        btn_left = 1'b1;
        repeat (3) do_tick();
        btn_left = 1'b0;
        n_cmp++;
        if (xpos !== 11'd516) begin
            n_err++;
            $display("FAIL move_left3: got %0d expected 516", xpos);
        end
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_err++;
            $display("FAIL move_model: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_clamp();
        apply_reset();
        btn_left = 1'b1;
        do_tick();
        btn_left = 1'b0;
        n_cmp++;
        if (e_xpos !== 11'd0) begin
            n_err++;
            $display("FAIL clamp_left: got %0d expected 0", e_xpos);
        end
        n_cmp++;
        if (xpos !== 11'd484) begin
            n_err++;
            $display("FAIL clamp_main_left: got %0d expected 484", xpos);
        end
        apply_reset();
        btn_right = 1'b1;
        repeat (243) do_tick();
        n_cmp++;
        if (e_xpos !== 11'd974) begin
            n_err++;
            $display("FAIL clamp_pre_right: got %0d expected 974", e_xpos);
        end
        do_tick();
        n_cmp++;
        if (e_xpos !== 11'd976) begin
            n_err++;
            $display("FAIL clamp_right: got %0d expected 976", e_xpos);
        end
        btn_left = 1'b1;
        repeat (2) do_tick();
        btn_left = 1'b0;
        btn_right = 1'b0;
        n_cmp++;
        if (e_xpos !== 11'd976) begin
            n_err++;
            $display("FAIL both_buttons_hold: got %0d expected 976", e_xpos);
        end
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_err++;
            $display("FAIL clamp_main_model: got %h expected %h", dut_vec, model_vec());
        end
    endtask

    task automatic test_hit_respawn();
        apply_reset();
        pulse_hit();
        n_cmp++;
        if ({dead_ship, lives} !== {1'b1, 2'd2}) begin
            n_err++;
            $display("FAIL hit_dead: got dead=%0d lives=%0d expected dead=1 lives=2", dead_ship, lives);
        end
        repeat (30) do_tick();
        pulse_hit();
        n_cmp++;
        if ({dead_ship, lives} !== {1'b1, 2'd2}) begin
            n_err++;
            $display("FAIL hit_in_dead: got dead=%0d lives=%0d expected dead=1 lives=2", dead_ship, lives);
        end
        repeat (29) do_tick();
        n_cmp++;
        if (dead_ship !== 1'b1) begin
            n_err++;
            $display("FAIL respawn_early: got dead=%0d expected 1 after 59 ticks", dead_ship);
        end
        do_tick();
        n_cmp++;
        if ({dead_ship, xpos} !== {1'b0, 11'd488}) begin
            n_err++;
            $display("FAIL respawn: got dead=%0d xpos=%0d expected dead=0 xpos=488", dead_ship, xpos);
        end
    endtask

    task automatic test_game_over();
        // continues from test_hit_respawn: ALIVE with 2 lives
        repeat (INV) do_tick();
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_err++;
            $display("FAIL start_in_alive: got %h expected %h", dut_vec, model_vec());
        end
        pulse_hit();
        repeat (RESPAWN) do_tick();
        repeat (INV) do_tick();
        pulse_hit();
        n_cmp++;
        if ({lives, game_over, dead_ship} !== {2'd0, 1'b1, 1'b1}) begin
            n_err++;
            $display("FAIL game_over: got lives=%0d go=%0d dead=%0d expected 0 1 1", lives, game_over, dead_ship);
        end
        btn_right = 1'b1;
        repeat (3) do_tick();
        pulse_hit();
        btn_right = 1'b0;
        n_cmp++;
        if (dut_vec !== model_vec()) begin
            n_err++;
            $display("FAIL over_ignores: got %h expected %h", dut_vec, model_vec());
        end
        start = 1'b1;
        cycle();
        start = 1'b0;
        n_cmp++;
        if (dut_vec !== {11'd488, 2'd3, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL restart: got %h expected %h", dut_vec, {11'd488, 2'd3, 1'b0, 1'b0});
        end
    endtask

    task automatic test_hit_tick();
        apply_reset();
        btn_right = 1'b1;
        vsync = 1'b1;
        hit = 1'b1;
        cycle();
        hit = 1'b0;
        vsync = 1'b0;
        cycle();
        btn_right = 1'b0;
        n_cmp++;
        if ({xpos, dead_ship} !== {11'd488, 1'b1}) begin
            n_err++;
            $display("FAIL hit_and_tick: got xpos=%0d dead=%0d expected 488 1", xpos, dead_ship);
        end
        repeat (5) do_tick();
        rst = 1'b1;
        #1;
        model_reset();
        n_cmp++;
        if (dut_vec !== {11'd488, 2'd3, 1'b0, 1'b0}) begin
            n_err++;
            $display("FAIL reset_mid_dead: got %h expected %h", dut_vec, {11'd488, 2'd3, 1'b0, 1'b0});
        end
        @(negedge pclk);
        rst = 1'b0;
    endtask

    task automatic test_invuln();
        apply_reset();
        pulse_hit();
        repeat (RESPAWN) do_tick();
`ifdef SHIP_INVULN_EN
        repeat (10) do_tick();
        pulse_hit();
        n_cmp++;
        if ({dead_ship, lives} !== {1'b0, 2'd2}) begin
            n_err++;
            $display("FAIL invuln_ignore: got dead=%0d lives=%0d expected 0 2", dead_ship, lives);
        end
        repeat (81) do_tick();
        pulse_hit();
        n_cmp++;
        if ({dead_ship, lives} !== {1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL invuln_expired: got dead=%0d lives=%0d expected 1 1", dead_ship, lives);
        end
`else
        pulse_hit();
        n_cmp++;
        if ({dead_ship, lives} !== {1'b1, 2'd1}) begin
            n_err++;
            $display("FAIL hit_after_respawn: got dead=%0d lives=%0d expected 1 1", dead_ship, lives);
        end
`endif
    endtask

    task automatic test_random();
        logic [14:0] exp_v;
        apply_reset();
        for (int i = 0; i < 3000; i++) begin
            vsync = ($urandom_range(0, 2) == 0);
            btn_left = ($urandom_range(0, 1) == 1);
            btn_right = ($urandom_range(0, 1) == 1);
            hit = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 9) == 0);
            cycle();
            exp_q.push_back(model_vec());
            exp_v = exp_q.pop_front();
            n_cmp++;
            if (dut_vec !== exp_v) begin
                n_err++;
                $display("FAIL random_cycle%0d: got %h expected %h", i, dut_vec, exp_v);
            end
        end
        vsync = 1'b0;
        btn_left = 1'b0;
        btn_right = 1'b0;
        hit = 1'b0;
        start = 1'b0;
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        model_reset();
        test_reset();
        test_move();
        test_clamp();
        test_hit_respawn();
        test_game_over();
        test_hit_tick();
        test_invuln();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
